ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences an external simple dual-port RAM.
- RAM has registered read, 1-cycle latency, DEPTH = 2**ADDR_WIDTH.
- Exposes valid/ready push and pop streams.
- Hides RAM read latency behind a 2-entry output skid buffer, so pop runs at full throughput.
- Buffers SPI flash data between the flash reader and downstream pixel consumers.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM.
ADDR_WIDTH, 6, RAM address width; DEPTH = 2**ADDR_WIDTH total entries.

Ports:
clock  in  1  sole clock; also drives both RAM clocks.
reset_n  in  1  synchronous, active-low reset.
flush  in  1  synchronous clear of all contents.
wr_data  in  DATA_WIDTH  push data.
wr_valid  in  1  push request.
wr_ready  out  1  push accepted when wr_valid && wr_ready.
rd_data  out  DATA_WIDTH  head-of-queue word.
rd_valid  out  1  rd_data valid.
rd_ready  in  1  pop when rd_valid && rd_ready.
level  out  ADDR_WIDTH+1  total entries held (RAM + in-flight + skid).
ram_data  out  DATA_WIDTH  to RAM data.
ram_write_addr  out  ADDR_WIDTH  to RAM write_addr.
ram_we  out  1  to RAM we.
ram_read_addr  out  ADDR_WIDTH  to RAM read_addr.
ram_q  in  DATA_WIDTH  from RAM q.

Behaviour:
Clock and reset:
- One clock. Reset is synchronous and active-low on reset_n.
- Reset or flush clears wr_ptr, rd_ptr, ram_count, skid entries, fetch_inflight and level to 0.
- Outputs after reset: rd_valid=0, level=0, wr_ready=1, ram_we=0, ram_write_addr=0, ram_read_addr=0.
- Reset has priority over flush; flush has priority over same-cycle push/pop/fetch.
- In-flight fetch data arriving the cycle after flush is discarded.

Push path:
- push = wr_valid && wr_ready && !flush.
- ram_we = push; ram_write_addr = wr_ptr; ram_data = wr_data.
- All three are combinational from registered state and inputs.
- wr_ready = (level < DEPTH), registered-state only; no same-cycle pop pass-through.
- On push: wr_ptr += 1 (mod DEPTH, natural wrap).

Fetch path:
- ram_read_addr = rd_ptr.
- fetch = (ram_count != 0) && (skid_count + fetch_inflight − pop) < 2 && !flush.
- On fetch: rd_ptr += 1 (wrap); RAM latches ram[rd_ptr]; fetch_inflight = 1 next cycle.
- ram_count next = ram_count + push − fetch.
- Read-after-write hazard is impossible: a word pushed at edge E is first fetchable at E+1.

Skid buffer:
- 2 entries, FIFO order.
- When fetch_inflight, ram_q is captured into the skid buffer at the next edge.
- rd_valid = skid_count != 0; rd_data = oldest entry (registered).
- pop removes the oldest entry.
- Simultaneous capture and pop keeps order: the remaining entry shifts to head, the new entry goes behind it.
- Skid overflow cannot occur (guaranteed by the fetch condition).

Level and latency:
- level next = level + push − pop. Bounded to 0..DEPTH.
- Push accepted at edge E0 into an empty FIFO → fetch at E1 → rd_valid=1 after E2 (2-cycle latency).
- Sustained push+pop every cycle gives 1 word/cycle after initial latency, with no bubbles.

Boundaries:
- Full (level=DEPTH): wr_ready=0; push with simultaneous pop is refused that cycle; wr_ready=1 the next cycle.
- Empty: rd_valid=0; rd_ready is ignored.
- Pointer wrap at DEPTH−1 → 0 is transparent to data order.
- Reset or flush mid-stream: the next accepted push is the first word subsequently read.

Test Plan:
1. Reset, push 0x01..0x05 back-to-back with rd_ready=0 → rd_valid rises 2 cycles after first accept; level=5; then drain with rd_ready=1 → 0x01..0x05 on 5 consecutive cycles; level=0; rd_valid=0.
2. Continuous push+pop (wr_valid=rd_ready=1) of 200 incrementing bytes → output matches input order; after initial latency, one word per cycle; level stays ≤3.
3. Push 64 words (DEPTH=64) with rd_ready=0 → wr_ready=0 at level=64; 65th push refused with ram_we=0; pop+push the same cycle → push refused; wr_ready=1 next cycle.
4. Push and pop 150 words with random wr_valid/rd_ready gaps → both pointers wrap twice; scoreboard matches exactly; level always equals pushes − pops.
5. Push 10 words, pop 3, assert flush one cycle during an in-flight fetch → next cycle level=0, rd_valid=0; push 0xAA → first popped word is 0xAA.
6. Assert reset_n=0 mid-stream for one cycle → same clear as flush; wr_ready=1, ram_read_addr=0, ram_write_addr=0.

Source files
------------

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: bundle of the push stream, the pop stream and the external
// simple dual-port RAM bus of ram_fifo_ctrl.
//   master : controller side (drives wr_ready, rd_*, ram_data/addr/we)
//   slave  : environment side (producer, consumer and RAM)
//   wr_data/wr_valid/wr_ready  push stream
//   rd_data/rd_valid/rd_ready  pop stream
//   ram_data/ram_write_addr/ram_we/ram_read_addr/ram_q  RAM ports
interface ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [DATA_WIDTH-1:0] ram_q;

  modport master (
    input  wr_data, wr_valid, rd_ready, ram_q,
    output wr_ready, rd_data, rd_valid, ram_data, ram_write_addr, ram_we, ram_read_addr
  );

  modport slave (
    output wr_data, wr_valid, rd_ready, ram_q,
    input  wr_ready, rd_data, rd_valid, ram_data, ram_write_addr, ram_we, ram_read_addr
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: single-clock FIFO controller sequencing an external simple
// dual-port RAM (registered read, 1-cycle latency, DEPTH = 2**ADDR_WIDTH).
// A 2-entry skid buffer in front of the pop port hides the RAM read latency
// so pops can proceed every cycle.
//   clock    sole clock (also clocks the RAM)
//   reset_n  synchronous active-low reset
//   flush    synchronous clear of all contents
//   level    entries held: RAM + in-flight fetch + skid buffer
//   fifo     push/pop streams and RAM bus (ram_fifo_ctrl_if.master)
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   level,
  ram_fifo_ctrl_if.master       fifo
);

  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_count;
  logic                  fetch_inflight;
  logic [DATA_WIDTH-1:0] skid0;  // head
  logic [DATA_WIDTH-1:0] skid1;
  logic [1:0]            skid_count;

  logic                  push;
  logic                  pop;
  logic                  fetch;
  logic                  capture;
  logic [1:0]            skid_demand;
  logic [DATA_WIDTH-1:0] skid0_next;
  logic [DATA_WIDTH-1:0] skid1_next;
  logic [1:0]            skid_count_next;

  always_comb begin
    fifo.wr_ready       = (level < FULL_LEVEL);
    fifo.rd_valid       = (skid_count != 2'd0);
    fifo.rd_data        = skid0;

    push                = fifo.wr_valid && fifo.wr_ready && !flush;
    pop                 = fifo.rd_valid && fifo.rd_ready && !flush;

    fifo.ram_we         = push;
    fifo.ram_write_addr = wr_ptr;
    fifo.ram_data       = fifo.wr_data;
    fifo.ram_read_addr  = rd_ptr;

    // Skid slots that will be claimed after this edge if no new fetch issues;
    // a fetch is only issued when a slot is guaranteed for its data.
    skid_demand = skid_count + {1'b0, fetch_inflight} - {1'b0, pop};
    fetch       = (ram_count != '0) && (skid_demand < 2'd2) && !flush;

    // Data of a fetch issued before a flush is dropped on arrival.
    capture     = fetch_inflight && !flush;
  end

  // Pop shifts the tail to the head first; a capture then lands in the first
  // free slot, so a simultaneous capture+pop keeps FIFO order.
  always_comb begin
    skid0_next      = skid0;
    skid1_next      = skid1;
    skid_count_next = skid_count;
    if (pop) begin
      skid0_next      = skid1;
      skid_count_next = skid_count_next - 2'd1;
    end
    if (capture) begin
      if (skid_count_next == 2'd0) begin
        skid0_next = fifo.ram_q;
      end else begin
        skid1_next = fifo.ram_q;
      end
      skid_count_next = skid_count_next + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ram_count      <= '0;
      fetch_inflight <= 1'b0;
      skid0          <= '0;
      skid1          <= '0;
      skid_count     <= '0;
      level          <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      ram_count      <= ram_count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(fetch);
      fetch_inflight <= fetch;
      skid0          <= skid0_next;
      skid1          <= skid1_next;
      skid_count     <= skid_count_next;
      level          <= level + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: self-checking bench for ram_fifo_ctrl with a behavioural
// registered-read RAM and a queue scoreboard of accepted push data.
module tb_ram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 2**AW;

  logic          clock;
  logic          reset_n;
  logic          flush;
  logic [AW:0]   level;

  ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .level   (level),
    .fifo    (bus.master)
  );

  // Behavioural simple dual-port RAM, registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (bus.ram_we) mem[bus.ram_write_addr] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_read_addr];
  end

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard and reference model, updated once per cycle at negedge
  // (inputs and registered outputs are stable there).
  logic [DW-1:0] sb[$];
  int            mlevel = 0;
  logic [AW-1:0] mwp    = '0;
  bit            mon_en = 0;
  int            cyc    = 0;
  bit            trk    = 0;
  int            maxlvl = 0;
  int            first_pop = -1;
  int            last_pop  = -1;

  always @(negedge clock) begin
    if (mon_en) begin
      logic exp_push;
      cyc++;
      if (!reset_n) begin
        sb.delete(); mlevel = 0; mwp = '0;
      end else if (flush) begin
        check("ram_we_flush", bus.ram_we, 0);
        sb.delete(); mlevel = 0; mwp = '0;
      end else begin
        check("level", level, mlevel);
        check("wr_ready", bus.wr_ready, (mlevel < DEPTH));
        if (mlevel == 0) check("rd_valid_empty", bus.rd_valid, 0);
        exp_push = bus.wr_valid && (mlevel < DEPTH);
        check("ram_we", bus.ram_we, exp_push);
        if (trk && level > maxlvl) maxlvl = level;
        if (bus.rd_valid && bus.rd_ready) begin
          if (sb.size() == 0) check("pop_unexpected", bus.rd_data, 32'hFFFF_FFFF);
          else check("rd_data", bus.rd_data, sb.pop_front());
          mlevel--;
          if (trk) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
          end
        end
        if (exp_push) begin
          check("ram_write_addr", bus.ram_write_addr, mwp);
          check("ram_data", bus.ram_data, bus.wr_data);
          sb.push_back(bus.wr_data);
          mwp++;
          mlevel++;
        end
      end
    end
  end

  // Push n incrementing words from base; pv/pr are % chances of wr_valid/rd_ready.
  task automatic run(input int n, input int pv, input int pr, input logic [DW-1:0] base);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < 5000) begin
      bus.wr_valid = ($urandom_range(99) < pv);
      bus.wr_data  = 8'(base + sent);
      bus.rd_ready = ($urandom_range(99) < pr);
      @(negedge clock);
      if (bus.wr_valid && bus.wr_ready) sent++;
      @(posedge clock); #1;
      guard++;
    end
    bus.wr_valid = 0;
    bus.rd_ready = 0;
    if (guard >= 5000) check("run_timeout", sent, n);
  endtask

  task automatic drain();
    int g = 0;
    bus.wr_valid = 0;
    bus.rd_ready = 1;
    while ((sb.size() != 0 || bus.rd_valid) && g < 500) begin
      @(posedge clock); #1;
      g++;
    end
    if (g >= 500) check("drain_timeout", sb.size(), 0);
    bus.rd_ready = 0;
    @(negedge clock);
    check("drain_level", level, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    clock = 0; reset_n = 0; flush = 0;
    bus.wr_valid = 0; bus.rd_ready = 0; bus.wr_data = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1; mon_en = 1;

    // Reset state
    @(negedge clock);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_level", level, 0);
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_waddr", bus.ram_write_addr, 0);
    check("rst_raddr", bus.ram_read_addr, 0);
    @(posedge clock); #1;

    // 1: five back-to-back pushes, rd_valid rises two cycles after first accept
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1; bus.wr_data = 8'(i + 1); bus.rd_ready = 0;
      @(negedge clock);
      check("t1_latency", bus.rd_valid, (i >= 3));
      @(posedge clock); #1;
    end
    bus.wr_valid = 0;
    @(negedge clock);
    check("t1_level5", level, 5);
    @(posedge clock); #1;
    bus.rd_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("t1_drain_valid", bus.rd_valid, (i < 5));
      @(posedge clock); #1;
    end
    bus.rd_ready = 0;
    @(negedge clock);
    check("t1_level0", level, 0);
    @(posedge clock); #1;

    // 2: continuous push+pop of 200 words, no bubbles, level peaks at 3
    trk = 1; maxlvl = 0; first_pop = -1; last_pop = -1;
    run(200, 100, 100, 8'h00);
    drain();
    trk = 0;
    check("t2_pop_span", last_pop - first_pop, 199);
    check("t2_max_level", maxlvl, 3);

    // 3: fill to DEPTH, refused pushes, push refused during pop at full
    run(DEPTH, 100, 0, 8'h40);
    @(negedge clock);
    check("t3_full_level", level, DEPTH);
    check("t3_full_ready", bus.wr_ready, 0);
    @(posedge clock); #1;
    bus.wr_valid = 1; bus.wr_data = 8'hFF;
    @(negedge clock);
    check("t3_refused_we", bus.ram_we, 0);
    @(posedge clock); #1;
    bus.rd_ready = 1;
    @(negedge clock);
    check("t3_pop_push_ready", bus.wr_ready, 0);
    check("t3_pop_push_we", bus.ram_we, 0);
    @(posedge clock); #1;
    bus.wr_valid = 0; bus.rd_ready = 0;
    @(negedge clock);
    check("t3_ready_after", bus.wr_ready, 1);
    check("t3_level_after", level, DEPTH - 1);
    @(posedge clock); #1;
    drain();

    // 4: random gaps on both sides, pointers wrap
    run(150, 60, 60, 8'h80);
    drain();

    // 5: flush while a fetch is in flight
    run(10, 100, 0, 8'h10);
    repeat (3) begin @(posedge clock); #1; end
    bus.rd_ready = 1;
    repeat (3) begin @(posedge clock); #1; end
    bus.rd_ready = 0; flush = 1;
    @(posedge clock); #1;
    flush = 0;
    @(negedge clock);
    check("t5_flush_level", level, 0);
    check("t5_flush_valid", bus.rd_valid, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("t5_discard_valid", bus.rd_valid, 0);
    @(posedge clock); #1;
    run(1, 100, 0, 8'hAA);
    drain();

    // 6: reset mid-stream
    run(7, 100, 0, 8'h30);
    reset_n = 0;
    @(posedge clock); #1;
    reset_n = 1;
    @(negedge clock);
    check("t6_wr_ready", bus.wr_ready, 1);
    check("t6_raddr", bus.ram_read_addr, 0);
    check("t6_waddr", bus.ram_write_addr, 0);
    check("t6_level", level, 0);
    check("t6_rd_valid", bus.rd_valid, 0);
    @(posedge clock); #1;
    run(1, 100, 0, 8'h5C);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
